uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing one UART_Tx instance among NUM_REQ byte producers.
//  - Accepts one byte from the winning requester per transaction.
//  - Issues a single-cycle i_TX_DV/i_TX_Byte to UART_Tx, then waits for o_TX_Done.
//  - Applies an optional inter-byte gap before re-arbitrating.
//  - Sits between application logic (sensor/log/debug sources) and the UART_Tx datapath.
// PARAMETERS
//  NUM_REQ      4      number of requesters, >= 2
//  GAP_CYCLES   0      idle clocks inserted after each o_TX_Done before next arbitration
//  DONE_TIMEOUT 200000 max clocks in WAIT_DONE before abort; 0 disables the watchdog
// PORTS
//  clk          in   1              system clock
//  rst          in   1              asynchronous reset, active-low
//  i_req_valid  in   NUM_REQ        requester k has a byte on i_req_byte[8k+:8]
//  i_req_byte   in   8*NUM_REQ      packed request bytes
//  o_req_ready  out  NUM_REQ        one-hot, 1-cycle pulse: byte of requester k consumed
//  o_TX_DV      out  1              to UART_Tx i_TX_DV, 1-cycle pulse
//  o_TX_Byte    out  8              to UART_Tx i_TX_Byte, held stable until next issue
//  i_TX_Active  in   1              from UART_Tx o_TX_Active
//  i_TX_Done    in   1              from UART_Tx o_TX_Done
//  o_grant_id   out  $clog2(NUM_REQ) index of the last/current granted requester
//  o_busy       out  1              high in every state except IDLE
//  o_timeout    out  1              1-cycle pulse when the DONE_TIMEOUT abort fires
// BEHAVIOUR
//  Reset (rst=0, async):
//  - All outputs 0; state IDLE; RR pointer 0; gap and timeout counters 0.
//  - Any in-flight byte is dropped; no o_req_ready is re-issued for it.
//  FSM states: IDLE -> ISSUE -> WAIT_DONE -> GAP -> IDLE.
//  IDLE:
//  - Requires |i_req_valid && !i_TX_Active.
//  - Search requesters from ptr upward, modulo NUM_REQ; first valid k wins.
//  - Same cycle: o_req_ready[k]=1, byte registered into o_TX_Byte, o_grant_id=k.
//  - ptr <= (k+1) mod NUM_REQ.
//  - Go to ISSUE.
//  ISSUE: o_TX_DV=1 for exactly this one cycle; go to WAIT_DONE.
//  WAIT_DONE:
//  - Wait for i_TX_Done=1; then go to GAP if GAP_CYCLES>0, else IDLE.
//  - Timeout counter increments each cycle in WAIT_DONE.
//  - If the count reaches DONE_TIMEOUT (nonzero): o_timeout pulse, go to IDLE.
//  GAP: count GAP_CYCLES clocks, then IDLE.
//  Latency:
//  - Request accept to o_TX_DV is 1 clk.
//  - Done to next accept is GAP_CYCLES+1 clk minimum.
//  Handshake:
//  - Requester must hold valid and byte stable until its o_req_ready pulse.
//  - Dropping valid before grant is allowed (request withdrawn).
//  Boundaries:
//  - All valid: strict rotation 0,1,2,3,0...
//  - Single valid requester: back-to-back bytes, no starvation gaps.
//  - ptr wraps NUM_REQ-1 -> 0.
//  - i_TX_Done outside WAIT_DONE is ignored.
//  - i_TX_Active=1 while in IDLE blocks grant.
// CONFIGURATION
//  UART_ARB_LOCK_EN defined:
//  - Adds input i_req_lock [NUM_REQ].
//  - If the granted requester holds i_req_lock high when the FSM returns to IDLE:
//    it keeps priority (ptr not advanced past it) and wins if valid.
//  - The lock is ignored if that requester is not valid, so the arbiter never stalls.
//  UART_ARB_LOCK_EN undefined: no i_req_lock port; pure per-byte round-robin.
// TESTING
//  1. Reset: assert rst=0 mid-WAIT_DONE -> all outputs 0; after release, ptr=0.
//  2. Single source: req0 sends 0x37 -> one o_TX_DV; UART_Rx loopback returns 0x37.
//  3. Fairness: all 4 valid with bytes 0xA0..0xA3 -> TX order A0,A1,A2,A3,A0;
//     each o_req_ready pulse is 1 clk.
//  4. Gap: GAP_CYCLES=5 -> exactly 6 clk from i_TX_Done to next o_req_ready.
//  5. Watchdog: DONE_TIMEOUT=100 with i_TX_Done tied 0 -> o_timeout at 100 clk;
//     FSM returns to IDLE.
//  6. Lock (UART_ARB_LOCK_EN): req2 locked for 3 bytes while req0/1 valid
//     -> order 2,2,2,then 0 (rotation resumes from 3 -> 0).

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if : requester bus and UART_Tx handshake for uart_tx_arbiter
// Optional: UART_ARB_LOCK_EN adds i_req_lock.   Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_byte;
  logic [NUM_REQ-1:0]   o_req_ready;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]   i_req_lock;
`endif
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active;
  logic                 i_TX_Done;
  logic [IW-1:0]        o_grant_id;
  logic                 o_busy;
  logic                 o_timeout;

  modport slave (
`ifdef UART_ARB_LOCK_EN
    input  i_req_lock,
`endif
    input  i_req_valid, i_req_byte, i_TX_Active, i_TX_Done,
    output o_req_ready, o_TX_DV, o_TX_Byte, o_grant_id, o_busy, o_timeout
  );

  modport master (
`ifdef UART_ARB_LOCK_EN
    output i_req_lock,
`endif
    output i_req_valid, i_req_byte, i_TX_Active, i_TX_Done,
    input  o_req_ready, o_TX_DV, o_TX_Byte, o_grant_id, o_busy, o_timeout
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter : round-robin sharing of one UART_Tx among NUM_REQ producers
// Optional: UART_ARB_LOCK_EN (sticky priority per requester).   Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int DONE_TIMEOUT = 200000
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [GW-1:0] c_GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] c_TO_LAST  = TW'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] c_LAST_ID  = IW'(NUM_REQ - 1);
  localparam bit            c_GAP_EN   = (GAP_CYCLES > 0);
  localparam bit            c_TO_EN    = (DONE_TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_gid;
  logic [7:0]          r_tx_byte;
  logic [GW-1:0]       r_gap_cnt;
  logic [TW-1:0]       r_to_cnt;

  logic [NUM_REQ-1:0]  w_valid;
  logic [IW-1:0]       w_start;
  logic [IW-1:0]       w_win;
  logic                w_any;
  logic                w_grant;
  logic                w_timeout;
  logic [7:0]          w_win_byte;
  logic [NUM_REQ-1:0]  w_ready;
  logic [IW-1:0]       w_ptr_nxt;
  int                  w_dist;
  int                  w_best;

  assign w_valid = bus.i_req_valid;

  // A locked, still-valid previous winner restarts the search at itself.
`ifdef UART_ARB_LOCK_EN
  assign w_start = (bus.i_req_lock[r_gid] && w_valid[r_gid]) ? r_gid : r_ptr;
`else
  assign w_start = r_ptr;
`endif

  // Winner is the valid requester with the smallest circular distance from w_start.
  always_comb begin
    w_win      = '0;
    w_any      = 1'b0;
    w_best     = NUM_REQ;
    w_dist     = 0;
    w_win_byte = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_dist = k - int'(w_start);
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if (w_valid[k] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_win      = IW'(k);
        w_any      = 1'b1;
        w_win_byte = bus.i_req_byte[8*k +: 8];
      end
    end
  end

  // Gated by rst so no ready pulse leaks out while reset is held.
  assign w_grant   = (r_state == S_IDLE) && w_any && !bus.i_TX_Active && rst;
  assign w_ptr_nxt = (w_win == c_LAST_ID) ? '0 : w_win + 1'b1;

  always_comb begin
    w_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_ready[k] = w_grant && (w_win == IW'(k));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.i_TX_Done) begin
          w_state_nxt = c_GAP_EN ? S_GAP : S_IDLE;
        end else if (c_TO_EN && (r_to_cnt == c_TO_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP:   if (r_gap_cnt == c_GAP_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gid     <= '0;
      r_tx_byte <= 8'h00;
      r_gap_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= (r_state == S_GAP)  ? r_gap_cnt + 1'b1 : '0;
      r_to_cnt  <= (r_state == S_WAIT) ? r_to_cnt + 1'b1  : '0;
      if (w_grant) begin
        r_ptr     <= w_ptr_nxt;
        r_gid     <= w_win;
        r_tx_byte <= w_win_byte;
      end
    end
  end

  assign bus.o_req_ready = w_ready;
  assign bus.o_TX_DV     = (r_state == S_ISSUE);
  assign bus.o_TX_Byte   = r_tx_byte;
  assign bus.o_grant_id  = w_grant ? w_win : r_gid;
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_timeout   = w_timeout;

endmodule

`default_nettype wire
